stream_demux_n: RTL and testbench
=================================

Name: stream_demux_n

Overview:
Parametrised 1-to-N streaming demultiplexer with valid/ready handshakes on the input and on every output channel.
- Routes each input beat to the output channel chosen by in_sel.
- Holds the routing decision for a whole packet, from first beat to the in_last beat.
- Each output channel has a one-entry output register.
- Sits between a single producer (e.g. a packet parser) and N per-channel consumers; generalises the combinational 1-to-8 demux to any width and channel count.

Parameters:
DATA_W, 8, width of each data beat.
N_OUT, 8, number of output channels (2..256).
SEL_W, 3, width of in_sel; must satisfy 2**SEL_W >= N_OUT (checked by elaboration-time assertion).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
in_data  in  DATA_W  input beat.
in_sel  in  SEL_W  destination channel; sampled only on the first beat of a packet.
in_last  in  1  marks the final beat of a packet.
in_valid  in  1  input beat present.
in_ready  out  1  block accepts the beat this cycle.
out_data  out  N_OUT*DATA_W  channel k data at bits [k*DATA_W +: DATA_W].
out_last  out  N_OUT  per-channel last flag.
out_valid  out  N_OUT  per-channel valid.
out_ready  in  N_OUT  per-channel consumer ready.
err_sel  out  1  one-cycle pulse: a packet with in_sel >= N_OUT was dropped.
busy  out  1  high while in LOCKED state.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - out_valid, out_last, out_data, err_sel all 0.
  - FSM in IDLE; latched sel = 0; busy = 0.
- Transfer rules:
  - An input beat transfers when in_valid & in_ready.
  - Output k transfers when out_valid[k] & out_ready[k].
- FSM states: IDLE, LOCKED, DROP.
  - IDLE, first beat transfers:
    - Latch in_sel.
    - If in_sel < N_OUT, route the beat; next state is LOCKED, or IDLE if in_last.
    - If in_sel >= N_OUT, discard the beat and assert err_sel the next cycle; next state is DROP, or IDLE if in_last.
  - LOCKED: route each beat to the latched channel and ignore in_sel. The in_last beat returns the FSM to IDLE.
  - DROP: in_ready = 1; beats are discarded and in_sel is ignored. The in_last beat returns the FSM to IDLE. err_sel pulses only once per packet.
- in_ready:
  - In IDLE/LOCKED: in_ready = !out_valid[t] | out_ready[t], where t is the target channel (in_sel in IDLE, latched sel in LOCKED).
  - For an invalid sel in IDLE, in_ready = 1.
  - in_ready is combinational from in_valid-independent signals and must not depend on in_valid.
- Latency: an accepted beat appears on out_data[t]/out_valid[t] on the next clock edge (1 cycle).
- Simultaneous drain and fill on the same channel in one cycle: the register is reloaded and out_valid[t] stays 1, giving full throughput of 1 beat/cycle.
- Per-channel output registers:
  - Data and last are held stable while out_valid[k] & !out_ready[k] (AXI-stream rule).
  - out_data is not cleared after a drain; only out_valid is meaningful.
- Non-target channels can drain independently while the input is stalled on the target channel.
- Reset mid-packet: everything clears immediately; the next accepted beat is treated as a first beat.
- err_sel: registered, exactly 1 cycle wide.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- When defined:
  - Adds input port in_bcast (1 bit), sampled on the first beat together with in_sel.
  - If in_bcast = 1, the packet is broadcast: every beat is written to all N_OUT channel registers in the same cycle.
  - in_ready = AND over k of (!out_valid[k] | out_ready[k]).
  - in_sel is ignored and no err_sel is raised.
  - The FSM uses an extra state BCAST, which behaves like LOCKED.
- When undefined: no in_bcast port, no BCAST state; behaviour is exactly as above.

Test Plan:
- After reset, in_sel=3, single-beat packet data=0xA5, last=1, all out_ready=1 -> next cycle out_valid=8'b0000_1000, out_data[3]=0xA5, out_last[3]=1; FSM back in IDLE.
- 4-beat packet with in_sel=5 on beat 0, in_sel toggled to 2 on beats 1..3 -> all 4 beats appear only on channel 5; busy=1 from beat 1 until the last-beat acceptance.
- Channel 6 out_ready=0, two packets sent to channel 6 -> first beat accepted, then in_ready=0. Raising out_ready[6] drains and refills in the same cycle with no bubble; channel 1 traffic still drains while channel 6 is stalled.
- N_OUT=5, SEL_W=3, 3-beat packet with in_sel=6 -> all beats accepted (in_ready=1), no out_valid asserted, err_sel high for exactly 1 cycle.
- Assert rst_n=0 mid-packet (LOCKED on channel 2) -> outputs and busy clear asynchronously. The next beat with in_sel=0 routes to channel 0.
- (DEMUX_BCAST_EN) in_bcast=1, 2-beat packet 0x11, 0x22 with all out_ready=1 -> all 8 channels show 0x11, then 0x22 with last=1. With out_ready[4]=0 and channel 4 full, in_ready=0.

Source files
------------

// File: rtl/stream_demux_n.sv
// 1-to-N valid/ready stream demultiplexer with per-packet routing lock and a
// one-entry output register per channel. Optional broadcast: DEMUX_BCAST_EN.
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_last,
`ifdef DEMUX_BCAST_EN
  input  logic                    in_bcast,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    err_sel,
  output logic                    busy
);

  if (N_OUT < 2 || N_OUT > 256 || (2**SEL_W) < N_OUT) begin : g_param_check
    $error("stream_demux_n: need 2 <= N_OUT <= 256 and 2**SEL_W >= N_OUT");
  end

`ifdef DEMUX_BCAST_EN
  typedef enum logic [1:0] {IDLE, LOCKED, DROP, BCAST} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOCKED, DROP} state_t;
`endif

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q;
  logic [N_OUT-1:0]          valid_q, last_q, load;
  logic [N_OUT*DATA_W-1:0]   data_q;
  logic                      err_q;

  logic [SEL_W-1:0]          tgt;
  logic                      tgt_ok, tgt_free, all_free, route, bcast_path, in_fire;

  // The target is the live in_sel on a first beat, the latched channel afterwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    tgt      = (state_q == IDLE) ? in_sel : sel_q;
    tgt_ok   = 32'(tgt) < 32'(N_OUT);
    tgt_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (tgt == SEL_W'(k)) tgt_free = !valid_q[k] | out_ready[k];
    end
    all_free = &(~valid_q | out_ready);
    route    = tgt_ok & ((state_q == IDLE) | (state_q == LOCKED));
`ifdef DEMUX_BCAST_EN
    bcast_path = ((state_q == IDLE) & in_bcast) | (state_q == BCAST);
`else
    bcast_path = 1'b0;
`endif
  end

  // Output process: in_ready never looks at in_valid.
  always_comb begin
    in_ready = 1'b1;
    busy     = 1'b0;
    if (bcast_path) begin
      in_ready = all_free;
    end else if (state_q != DROP && tgt_ok) begin
      in_ready = tgt_free;
    end
`ifdef DEMUX_BCAST_EN
    busy = (state_q == LOCKED) | (state_q == BCAST);
`else
    busy = (state_q == LOCKED);
`endif
  end

  assign in_fire = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      if (in_last) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
`ifdef DEMUX_BCAST_EN
        if (bcast_path)  state_d = BCAST;
        else
`endif
        if (tgt_ok)      state_d = LOCKED;
        else             state_d = DROP;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = in_fire & (bcast_path | (route & (tgt == SEL_W'(k))));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_fire && state_q == IDLE) sel_q <= in_sel;
      err_q <= in_fire & (state_q == IDLE) & !bcast_path & !tgt_ok;
    end
  end

  // Drain-and-fill in one cycle keeps valid high: load wins over the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too because out_data must read 0
      // out of reset; this is a small register file, not a RAM.
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= load | (valid_q & ~out_ready);
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          data_q[k*DATA_W +: DATA_W] <= in_data;
          last_q[k]                  <= in_last;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign err_sel   = err_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboard bench for stream_demux_n: a packet-level model predicts per-channel
// beat queues, in_ready, busy and err_sel; a negedge monitor compares.
module tb_stream_demux_n;
  localparam int DATA_W = 8;
  localparam int N_OUT  = 8;
  localparam int SEL_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [DATA_W-1:0]       in_data = '0;
  logic [SEL_W-1:0]        in_sel = '0;
  logic                    in_last = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_last, out_valid;
  logic [N_OUT-1:0]        out_ready = '1;
  logic                    err_sel, busy;
`ifdef DEMUX_BCAST_EN
  logic                    in_bcast = 1'b0;
`endif

  stream_demux_n #(.DATA_W(DATA_W), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_last(in_last),
`ifdef DEMUX_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .err_sel(err_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t exq[N_OUT][$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    in_pkt = 0;
  int    pkt_ch = 0;
  bit    exp_err = 0;

  logic [N_OUT-1:0] rdy_force_lo = '0;
  bit               rdy_rand = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor / reference model: everything sampled here transfers at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err_sel", 64'(err_sel), 64'd0);
      for (int k = 0; k < N_OUT; k++) exq[k].delete();
      in_pkt  = 0;
      pkt_ch  = 0;
      exp_err = 0;
    end else begin
      int t;
      bit er;
      check("err_sel", 64'(err_sel), 64'(exp_err));
      check("busy", 64'(busy), 64'(in_pkt && pkt_ch >= 0));
      t  = in_pkt ? pkt_ch : int'(in_sel);
      er = (t < 0 || t >= N_OUT) ? 1'b1 : (exq[t].size() == 0 || out_ready[t]);
      check("in_ready", 64'(in_ready), 64'(er));
      for (int k = 0; k < N_OUT; k++) begin
        check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(exq[k].size() != 0));
        if (out_valid[k] && out_ready[k] && exq[k].size() != 0) begin
          beat_t b;
          b = exq[k].pop_front();
          check($sformatf("out_data[%0d]", k), 64'(out_data[k*DATA_W +: DATA_W]), 64'(b.data));
          check($sformatf("out_last[%0d]", k), 64'(out_last[k]), 64'(b.last));
        end
      end
      exp_err = 0;
      if (in_valid && in_ready) begin
        if (!in_pkt) begin
          pkt_ch  = (int'(in_sel) < N_OUT) ? int'(in_sel) : -1;
          exp_err = (pkt_ch < 0);
        end
        if (pkt_ch >= 0) exq[pkt_ch].push_back('{data: in_data, last: in_last});
        in_pkt = !in_last;
      end
    end
  end

  // Consumer ready generator, offset from the input driver.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = (rdy_rand ? N_OUT'($urandom) : '1) & ~rdy_force_lo;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d,
                            input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    in_last  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout @%0t: in_ready stuck at 0, expected 1 within 300 cycles", $time);
    end
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int sel, input int len, input int gap);
    for (int b = 0; b < len; b++) begin
      logic [SEL_W-1:0] s;
      s = (b == 0) ? SEL_W'(sel) : SEL_W'($urandom);
      drive_beat(s, DATA_W'($urandom), b == len - 1);
      repeat ($urandom_range(0, gap)) next_cycle();
    end
  endtask

  initial begin
    repeat (2) next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single-beat packet to channel 3.
    drive_beat(SEL_W'(3), 8'hA5, 1'b1);
    next_cycle();

    // Four beats locked on channel 5 while in_sel moves to 2.
    drive_beat(SEL_W'(5), 8'h10, 1'b0);
    drive_beat(SEL_W'(2), 8'h11, 1'b0);
    drive_beat(SEL_W'(2), 8'h12, 1'b0);
    drive_beat(SEL_W'(2), 8'h13, 1'b1);
    next_cycle();

    // Channel 6 stalled, channel 1 holding a beat; ch1 drains first, then ch6 refills.
    rdy_force_lo = N_OUT'(8'b0100_0010);
    drive_beat(SEL_W'(1), 8'h21, 1'b1);
    drive_beat(SEL_W'(6), 8'h61, 1'b1);
    fork
      drive_beat(SEL_W'(6), 8'h62, 1'b1);
      begin
        repeat (4) next_cycle();
        rdy_force_lo = N_OUT'(8'b0100_0000);
        repeat (4) next_cycle();
        rdy_force_lo = '0;
      end
    join
    repeat (3) next_cycle();

    // Out-of-range selects, including the first invalid value and the top one.
    send_pkt(9, 3, 0);
    send_pkt(8, 1, 1);
    send_pkt(15, 2, 0);
    send_pkt(7, 2, 0);
    repeat (2) next_cycle();

    // Reset while locked on channel 2; the next beat is a fresh first beat.
    drive_beat(SEL_W'(2), 8'h2A, 1'b0);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    drive_beat(SEL_W'(0), 8'h0F, 1'b1);
    next_cycle();

    // Randomized traffic with back-pressure.
    rdy_rand = 1;
    for (int p = 0; p < 80; p++) begin
      send_pkt(int'($urandom_range(0, 2**SEL_W - 1)), int'($urandom_range(1, 5)), 2);
    end
    rdy_rand = 0;
    repeat (6) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
